div_sequencer: RTL and testbench

//  Multi-cycle DIV/DIVU sequencer. Borrows the shared 32-bit ALU in SUBU mode (aluc=4'b0001,

---
 rtl/div_sequencer_pkg.sv | 21 ++
 rtl/div_sequencer.sv | 146 ++++++++++++++
 tb/tb_div_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared constants for the DIV/DIVU sequencer: ALU opcodes and sequencer state encodings.
// The ALU itself lives in the CPU datapath; only its opcode values are mirrored here.
package div_sequencer_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   localparam logic [3:0] ALUC_ADDU = 4'b0000;
   localparam logic [3:0] ALUC_SUBU = 4'b0001;
   localparam logic [3:0] ALUC_AND  = 4'b0100;
   localparam logic [3:0] ALUC_OR   = 4'b0101;

   typedef enum logic [2:0] {
      DIV_ST_IDLE = 3'd0,
      DIV_ST_PREP = 3'd1,
      DIV_ST_ITER = 3'd2,
      DIV_ST_FIX  = 3'd3,
      DIV_ST_DONE = 3'd4
   } div_state_t;

endpackage

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider that borrows the shared ALU (SUBU) for its trial subtractions.
// Produces HI (remainder) / LO (quotient) with MIPS truncate-toward-zero semantics.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// PREP  | take magnitudes, seed partial remainder; divisor==0 skips to FIX
// ITER  | 32 shift/subtract steps, ALU owned by this block
// FIX   | restore signs (or load divide-by-zero result) into hi/lo
// DONE  | one-cycle done pulse
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             alu_req,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_aluc,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_carry,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   div_state_t       state;
   logic             is_signed_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic             sd;
   logic             sv;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] abs_dvd;
   logic [WIDTH-1:0] abs_dvs;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   assign abs_dvd = (is_signed_q && dividend_q[WIDTH-1]) ? -dividend_q : dividend_q;
   assign abs_dvs = (is_signed_q && divisor_q[WIDTH-1])  ? -divisor_q  : divisor_q;

   // Borrow means the trial subtraction failed: keep the shifted remainder, quotient bit 0.
   assign rem_nxt = alu_carry ? alu_a : alu_r;
   assign quo_nxt = {quo[WIDTH-2:0], ~alu_carry};

   assign alu_aluc = ALUC_SUBU;
   assign busy     = (state != DIV_ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= DIV_ST_IDLE;
         is_signed_q <= 1'b0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         sd          <= 1'b0;
         sv          <= 1'b0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         alu_req     <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         done        <= 1'b0;
         div_zero    <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state   <= DIV_ST_IDLE;
            alu_req <= 1'b0;
         end else begin
            unique case (state)
               DIV_ST_IDLE: begin
                  if (start) begin
                     is_signed_q <= is_signed;
                     dividend_q  <= dividend;
                     divisor_q   <= divisor;
                     state       <= DIV_ST_PREP;
                  end
               end
               DIV_ST_PREP: begin
                  sd  <= is_signed_q & dividend_q[WIDTH-1];
                  sv  <= is_signed_q & divisor_q[WIDTH-1];
                  rem <= '0;
                  quo <= abs_dvd;
                  cnt <= '0;
                  if (divisor_q == '0) begin
                     state <= DIV_ST_FIX;
                  end else begin
                     // ALU operands are registered, so the first step's inputs are staged here.
                     state   <= DIV_ST_ITER;
                     alu_req <= 1'b1;
                     alu_a   <= {{(WIDTH-1){1'b0}}, abs_dvd[WIDTH-1]};
                     alu_b   <= abs_dvs;
                  end
               end
               DIV_ST_ITER: begin
                  rem <= rem_nxt;
                  quo <= quo_nxt;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == '1) begin
                     state   <= DIV_ST_FIX;
                     alu_req <= 1'b0;
                  end else begin
                     alu_a <= {rem_nxt[WIDTH-2:0], quo[WIDTH-2]};
                  end
               end
               DIV_ST_FIX: begin
                  if (divisor_q == '0) begin
                     lo       <= '1;
                     hi       <= dividend_q;
                     div_zero <= 1'b1;
                  end else begin
                     lo       <= (sd ^ sv) ? -quo : quo;
                     hi       <= sd ? -rem : rem;
                     div_zero <= 1'b0;
                  end
                  done  <= 1'b1;
                  state <= DIV_ST_DONE;
               end
               DIV_ST_DONE: begin
                  state <= DIV_ST_IDLE;
               end
               default: begin
                  state   <= DIV_ST_IDLE;
                  alu_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: external ALU model, arithmetic reference model checked every cycle,
// directed corner cases with literal results, then randomized operations with flushes and stray starts.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        alu_req;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_aluc;
   logic [31:0] alu_r;
   logic        alu_carry;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign alu_r     = alu_a - alu_b;
   assign alu_carry = (alu_a < alu_b);

   div_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .flush(flush),
      .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
      .alu_r(alu_r), .alu_carry(alu_carry), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // MIPS division from plain 64-bit arithmetic: truncation toward zero, remainder follows dividend.
   function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r, output bit dz);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = '1; r = a; dz = 1'b1;
         return;
      end
      dz = 1'b0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
   endfunction

   // Reference model: time since acceptance decides what the outputs must be.
   bit          m_active = 1'b0;
   bit          m_done = 1'b0;
   int          m_t = 0;
   int          m_fin = 0;
   logic [31:0] p_hi, p_lo, m_dvd_mag, m_dvs_mag;
   bit          p_dz;
   logic [31:0] e_hi = '0, e_lo = '0;
   bit          e_dz = 1'b0;

   always @(posedge clk) begin
      logic        exp_req;
      logic [63:0] part;
      logic [31:0] exp_a;
      int          i;
      if (!rst_n) begin
         m_active = 1'b0; m_done = 1'b0;
         e_hi = '0; e_lo = '0; e_dz = 1'b0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_active = 1'b0;
         end else if (m_active) begin
            m_t++;
            if (m_t == m_fin) begin
               e_hi = p_hi; e_lo = p_lo; e_dz = p_dz; m_done = 1'b1;
            end else if (m_t > m_fin) begin
               m_active = 1'b0;
            end
         end else if (start) begin
            m_active = 1'b1;
            m_t = 0;
            ref_div(is_signed, dividend, divisor, p_lo, p_hi, p_dz);
            m_fin = p_dz ? 2 : 34;
            m_dvd_mag = (is_signed && dividend[31]) ? -dividend : dividend;
            m_dvs_mag = (is_signed && divisor[31])  ? -divisor  : divisor;
         end
      end
      exp_req = m_active && !p_dz && (m_t >= 1) && (m_t <= 32);
      #1;
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("alu_req", alu_req, exp_req);
      chk("alu_aluc", alu_aluc, 32'h1);
      chk("hi", hi, e_hi);
      chk("lo", lo, e_lo);
      chk("div_zero", div_zero, e_dz);
      if (exp_req) begin
         // Step i sees 2*(leading dividend bits mod divisor) plus the next dividend bit.
         i = m_t - 1;
         part = {32'd0, m_dvd_mag} >> (32 - i);
         part = part % {32'd0, m_dvs_mag};
         exp_a = 32'(part * 2) | {31'd0, m_dvd_mag[31-i]};
         chk("alu_a", alu_a, exp_a);
         chk("alu_b", alu_b, m_dvs_mag);
      end
   end

   task automatic wait_done(output int lat, output int nreq);
      lat = 0; nreq = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #2;
         lat++;
         if (alu_req) nreq++;
      end
   endtask

   task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output int nreq);
      @(negedge clk);
      start = 1'b1; is_signed = s; dividend = a; divisor = b;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done(lat, nreq);
      @(posedge clk); #2;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nreq, k;
      logic [31:0] q, r;
      bit dz;
      bit seen;

      ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dz);
      chk("model_neg7_div2_q", q, 32'hFFFF_FFFD);
      chk("model_neg7_div2_r", r, 32'hFFFF_FFFF);
      ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz);
      chk("model_minint_q", q, 32'h8000_0000);
      chk("model_minint_r", r, 32'h0);

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_alu_req", alu_req, 0);
      chk("rst_div_zero", div_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      rst_n = 1'b1;

      op(1'b0, 32'd100, 32'd7, lat, nreq);
      chk("divu100_7_latency", lat, 34);
      chk("divu100_7_alu_cycles", nreq, 32);
      chk("divu100_7_lo", lo, 14);
      chk("divu100_7_hi", hi, 2);
      chk("divu100_7_dz", div_zero, 0);

      op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, nreq);
      chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
      chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
      op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, nreq);
      chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
      chk("div_7_m2_hi", hi, 32'd1);

      op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, nreq);
      chk("div_minint_lo", lo, 32'h8000_0000);
      chk("div_minint_hi", hi, 32'd0);
      op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, nreq);
      chk("divu_max_1_lo", lo, 32'hFFFF_FFFF);
      chk("divu_max_1_hi", hi, 32'd0);

      op(1'b0, 32'd5, 32'd0, lat, nreq);
      chk("divz_latency", lat, 2);
      chk("divz_alu_cycles", nreq, 0);
      chk("divz_dz", div_zero, 1);
      chk("divz_lo", lo, 32'hFFFF_FFFF);
      chk("divz_hi", hi, 32'd5);

      // Flush in the middle of the iterations: result registers must keep the 5/0 result.
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #2; flush = 1'b0;
      chk("flush_busy", busy, 0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #2;
         if (done) seen = 1'b1;
      end
      chk("flush_no_done", seen, 0);
      chk("flush_lo_kept", lo, 32'hFFFF_FFFF);
      chk("flush_hi_kept", hi, 32'd5);
      chk("flush_dz_kept", div_zero, 1);

      // start together with flush in IDLE must not launch an operation.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; dividend = 32'd8; divisor = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_beats_start", busy, 0);

      // A second start while busy is ignored.
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; dividend = 32'd77; divisor = 32'd2;
      @(negedge clk); start = 1'b0;
      wait_done(lat, nreq);
      @(posedge clk); #2;
      chk("restart_ignored_lo", lo, 32'd10);
      chk("restart_ignored_hi", hi, 32'd0);

      // Asynchronous reset at iteration 20.
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd123456; divisor = 32'd7;
      @(posedge clk); #2; start = 1'b0;
      repeat (21) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_alu_req", alu_req, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      op(1'b0, 32'd9, 32'd3, lat, nreq);
      chk("after_rst_lo", lo, 32'd3);
      chk("after_rst_hi", hi, 32'd0);

      for (int n = 0; n < 60; n++) begin
         int mode;
         @(negedge clk);
         start = 1'b1; is_signed = 1'($urandom_range(0, 1));
         dividend = pick(); divisor = pick();
         @(negedge clk); start = 1'b0;
         mode = $urandom_range(0, 7);
         if (mode == 0) begin
            repeat ($urandom_range(0, 36)) @(negedge clk);
            flush = 1'b1;
            @(negedge clk); flush = 1'b0;
         end else if (mode == 1) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            start = 1'b1; dividend = $urandom; divisor = pick();
            @(negedge clk); start = 1'b0;
         end
         k = 0;
         while (busy && k < 100) begin
            @(negedge clk);
            k++;
         end
         tests++;
         if (k >= 100) begin
            fails++;
            $display("FAIL rand_timeout: op %0d still busy after %0d cycles, required idle", n, k);
         end
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
